// File: rtl/traffic_pkg.sv
// Shared state encoding, default timing and width helper for the intersection controller.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_WALK   = 2'd3
    } state_t;

    localparam int DEF_TICK_DIV = 50_000_000;
    localparam int DEF_N_APP    = 2;
    localparam int DEF_T_GREEN  = 10;
    localparam int DEF_T_YELLOW = 3;
    localparam int DEF_T_ALLRED = 1;
    localparam int DEF_T_WALK   = 5;
    localparam int DEF_CNT_W    = 8;

    // A single approach index still needs one bit of port width.
    function automatic int app_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/traffic_ctrl_multi_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_gen
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Round-robin N-approach intersection controller with latched pedestrian WALK requests.
// Optional build macro TRAFFIC_FLASH_EN adds a flash_mode input (flashing yellow, FSM parked in ALLRED).
module traffic_ctrl_multi
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int N_APP    = DEF_N_APP,
    parameter int T_GREEN  = DEF_T_GREEN,
    parameter int T_YELLOW = DEF_T_YELLOW,
    parameter int T_ALLRED = DEF_T_ALLRED,
    parameter int T_WALK   = DEF_T_WALK,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef TRAFFIC_FLASH_EN
    input  logic                      flash_mode,
`endif
    input  logic [N_APP-1:0]          ped_req,
    output logic [N_APP-1:0]          red,
    output logic [N_APP-1:0]          yellow,
    output logic [N_APP-1:0]          green,
    output logic [N_APP-1:0]          walk,
    output logic [app_w(N_APP)-1:0]   cur_app,
    output logic                      tick
);

    localparam int AW = app_w(N_APP);
    localparam logic [AW-1:0] LAST_APP = AW'(N_APP - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [AW-1:0]      cur_q, cur_d, next_app;
    logic [N_APP-1:0]   ped_q, ped_d, ped_clr;
    logic [N_APP-1:0]   red_q, red_d, yellow_q, yellow_d, green_q, green_d, walk_q, walk_d;
    logic               tick_w;
`ifdef TRAFFIC_FLASH_EN
    logic               flash_ph_q, flash_ph_d;
`endif

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_w)
    );

    function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
        logic [CNT_W-1:0] d;
        d = CNT_W'(T_ALLRED - 1);
        case (s)
            ST_GREEN:  d = CNT_W'(T_GREEN - 1);
            ST_YELLOW: d = CNT_W'(T_YELLOW - 1);
            ST_ALLRED: d = CNT_W'(T_ALLRED - 1);
            ST_WALK:   d = CNT_W'(T_WALK - 1);
        endcase
        return d;
    endfunction

    // Explicit wrap keeps non-power-of-2 approach counts in range.
    assign next_app = (cur_q == LAST_APP) ? '0 : cur_q + 1'b1;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d  = state_q;
        timer_d  = timer_q;
        cur_d    = cur_q;
        ped_clr  = '0;
        if (tick_w) begin
            if (timer_q == '0) begin
                case (state_q)
                    ST_GREEN:  state_d = ST_YELLOW;
                    ST_YELLOW: state_d = ST_ALLRED;
                    ST_ALLRED: begin
                        if (ped_q[cur_q]) begin
                            state_d        = ST_WALK;
                            ped_clr[cur_q] = 1'b1;
                        end else begin
                            state_d = ST_GREEN;
                            cur_d   = next_app;
                        end
                    end
                    ST_WALK: begin
                        state_d = ST_GREEN;
                        cur_d   = next_app;
                    end
                endcase
                timer_d = dur_m1(state_d);
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
`ifdef TRAFFIC_FLASH_EN
        flash_ph_d = 1'b0;
        if (flash_mode) begin
            state_d    = ST_ALLRED;
            timer_d    = dur_m1(ST_ALLRED);
            cur_d      = cur_q;
            ped_clr    = '0;
            flash_ph_d = flash_ph_q ^ tick_w;
        end
`endif
        // A new press in the same cycle as the clear keeps the bit set.
        ped_d = (ped_q & ~ped_clr) | ped_req;

        for (int i = 0; i < N_APP; i++) begin
            green_d[i]  = (state_d == ST_GREEN)  && (cur_d == AW'(i));
            yellow_d[i] = (state_d == ST_YELLOW) && (cur_d == AW'(i));
            walk_d[i]   = (state_d == ST_WALK)   && (cur_d == AW'(i));
        end
        red_d = ~(green_d | yellow_d);
`ifdef TRAFFIC_FLASH_EN
        if (flash_mode) begin
            green_d  = '0;
            walk_d   = '0;
            red_d    = '0;
            yellow_d = {N_APP{flash_ph_d}};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ALLRED;
            timer_q  <= CNT_W'(T_ALLRED - 1);
            cur_q    <= LAST_APP;
            ped_q    <= '0;
            red_q    <= '1;
            yellow_q <= '0;
            green_q  <= '0;
            walk_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cur_q    <= cur_d;
            ped_q    <= ped_d;
            red_q    <= red_d;
            yellow_q <= yellow_d;
            green_q  <= green_d;
            walk_q   <= walk_d;
        end
    end

`ifdef TRAFFIC_FLASH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) flash_ph_q <= 1'b0;
        else     flash_ph_q <= flash_ph_d;
    end
`endif

    assign red     = red_q;
    assign yellow  = yellow_q;
    assign green   = green_q;
    assign walk    = walk_q;
    assign cur_app = cur_q;
    assign tick    = tick_w;

endmodule
